alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational 16-bit Hack ALU.
- Same six control bits (zx, nx, zy, ny, f, no) and the same 18-function encoding, generalised to WIDTH bits.
- Adds registered zr/ng status flags and valid/ready handshakes on both sides, with full backpressure.
- Sits between the CPU decode stage and writeback, and also serves as a standalone ALU test vehicle.

---
 rtl/alu_pipe.sv | 147 ++++++++++++++
 tb/tb_alu_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack-style ALU with valid/ready handshakes and zr/ng status.
// Define ALU_PIPE_FLAGS_EN to also register the adder carry-out and signed overflow.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned MSB = WIDTH - 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] xp_q, xp_d, yp_q, yp_d;
  logic             f_q, f_d, no_q, no_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d;

  logic             s2_adv, s1_adv, s1_load;
  logic [WIDTH-1:0] xz_c, yz_c, xp_c, yp_c;
  logic [WIDTH-1:0] sum_c, r_c, res_c;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_load  = in_valid && in_ready;

  // Operand conditioning: optional zero, then optional invert.
  always_comb begin
    xz_c = ctrl[5] ? '0 : x;
    xp_c = ctrl[4] ? ~xz_c : xz_c;
    yz_c = ctrl[3] ? '0 : y;
    yp_c = ctrl[2] ? ~yz_c : yz_c;
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic cout_c;
  assign {cout_c, sum_c} = {1'b0, xp_q} + {1'b0, yp_q};
`else
  assign sum_c = xp_q + yp_q;
`endif

  always_comb begin
    r_c   = f_q ? sum_c : (xp_q & yp_q);
    res_c = no_q ? ~r_c : r_c;
  end

  // Next-state for both stages; stage 2 only reloads when a real op moves up,
  // so outputs keep their last value through bubbles.
  always_comb begin
    s1_valid_d = s1_valid_q;
    xp_d       = xp_q;
    yp_d       = yp_q;
    f_d        = f_q;
    no_d       = no_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zr_d       = zr_q;
    ng_d       = ng_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s1_load) begin
      xp_d = xp_c;
      yp_d = yp_c;
      f_d  = ctrl[1];
      no_d = ctrl[0];
    end
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s1_adv) begin
      out_d = res_c;
      zr_d  = (res_c == '0);
      ng_d  = res_c[MSB];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      xp_q       <= '0;
      yp_q       <= '0;
      f_q        <= 1'b0;
      no_q       <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      f_q        <= f_d;
      no_q       <= no_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;

`ifdef ALU_PIPE_FLAGS_EN
  logic carry_q, carry_d, ovf_q, ovf_d;

  // Flags come from the raw add, before the output inversion.
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (s1_adv) begin
      carry_d = f_q && cout_c;
      ovf_d   = f_q && (xp_q[MSB] == yp_q[MSB]) && (sum_c[MSB] != xp_q[MSB]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry = carry_q;
  assign ovf   = ovf_q;
`else
  assign carry = 1'b0;
  assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: canonical-function table, backpressure, reset, bubbles, flags.
module tb_alu_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, out;
  logic [5:0]  ctrl;
  logic        zr, ng, carry, ovf;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  x8, y8, out8;
  logic [5:0]  ctrl8;
  logic        zr8, ng8, carry8, ovf8;

  alu_pipe #(.WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .carry(carry), .ovf(ovf)
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .ctrl(ctrl8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .zr(zr8), .ng(ng8), .carry(carry8), .ovf(ovf8)
  );

  typedef struct {
    logic [5:0]  ctrl;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        fchk;
    logic        carry;
    logic        ovf;
  } exp_t;

  vec_t tbl[18];
  int   n_tbl = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  logic lat_en = 1'b0;
  logic exp_carry, exp_ovf, exp_ovf8;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic [5:0] c, input logic [15:0] o, input logic z, input logic n);
    tbl[n_tbl] = '{c, 16'h000A, 16'h0003, o, z, n};
    n_tbl++;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    acc_q.delete();
  endtask

  // Scoreboard: compare each transferred result in order, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out", 32'(out), 32'(e.out));
          chk("zr", 32'(zr), 32'(e.zr));
          chk("ng", 32'(ng), 32'(e.ng));
          if (e.fchk) begin
            chk("carry", 32'(carry), 32'(e.carry));
            chk("ovf", 32'(ovf), 32'(e.ovf));
          end
`ifndef ALU_PIPE_FLAGS_EN
          chk("carry_tied", 32'(carry), 32'd0);
          chk("ovf_tied", 32'(ovf), 32'd0);
`endif
          if (lat_en && acc_q.size() != 0) chk("latency", 32'(cyc_n - acc_q.pop_front()), 32'd2);
        end
      end
      if (lat_en && in_valid && in_ready) acc_q.push_back(cyc_n);
    end
  end

  initial begin
`ifdef ALU_PIPE_FLAGS_EN
    exp_carry = 1'b1;
    exp_ovf8  = 1'b1;
`else
    exp_carry = 1'b0;
    exp_ovf8  = 1'b0;
`endif
    exp_ovf = 1'b0;

    addv(6'b101010, 16'h0000, 1'b1, 1'b0);
    addv(6'b111111, 16'h0001, 1'b0, 1'b0);
    addv(6'b111010, 16'hFFFF, 1'b0, 1'b1);
    addv(6'b001100, 16'h000A, 1'b0, 1'b0);
    addv(6'b110000, 16'h0003, 1'b0, 1'b0);
    addv(6'b001101, 16'hFFF5, 1'b0, 1'b1);
    addv(6'b110001, 16'hFFFC, 1'b0, 1'b1);
    addv(6'b001111, 16'hFFF6, 1'b0, 1'b1);
    addv(6'b110011, 16'hFFFD, 1'b0, 1'b1);
    addv(6'b011111, 16'h000B, 1'b0, 1'b0);
    addv(6'b110111, 16'h0004, 1'b0, 1'b0);
    addv(6'b001110, 16'h0009, 1'b0, 1'b0);
    addv(6'b110010, 16'h0002, 1'b0, 1'b0);
    addv(6'b000010, 16'h000D, 1'b0, 1'b0);
    addv(6'b010011, 16'h0007, 1'b0, 1'b0);
    addv(6'b000111, 16'hFFF9, 1'b0, 1'b1);
    addv(6'b000000, 16'h0002, 1'b0, 1'b0);
    addv(6'b010101, 16'h000B, 1'b0, 1'b0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; ctrl = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; x8 = '0; y8 = '0; ctrl8 = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zr", 32'(zr), 32'd0);
    chk("rst_ng", 32'(ng), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Canonical functions back-to-back
    out_ready = 1'b1;
    lat_en = 1'b1;
    for (int i = 0; i < n_tbl; i++) begin
      in_valid = 1'b1; x = tbl[i].x; y = tbl[i].y; ctrl = tbl[i].ctrl;
      exp_q.push_back('{tbl[i].out, tbl[i].zr, tbl[i].ng, 1'b0, 1'b0, 1'b0});
      cyc();
    end
    in_valid = 1'b0;
    drain();
    lat_en = 1'b0;

    // Backpressure mid-stream
    ctrl = 6'b000010; y = 16'h0001;
    in_valid = 1'b1; x = 16'h0001; exp_q.push_back('{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    cyc();
    x = 16'h0002; exp_q.push_back('{16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    cyc();
    x = 16'h0003; out_ready = 1'b0;
    #1;
    chk("bp_first_out", 32'(out), 32'h0002);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_out", 32'(out), 32'h0002);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    cyc();
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    cyc();
    x = 16'h0004; exp_q.push_back('{16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    cyc();
    in_valid = 1'b0;
    drain();

    // Reset with two ops in flight: neither may emerge
    out_ready = 1'b0; in_valid = 1'b1; x = 16'h0005; y = 16'h0001;
    cyc();
    x = 16'h0006;
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(out_valid), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_zr", 32'(zr), 32'd0);
    chk("midrst_ng", 32'(ng), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) cyc();

    // Bubbles: out_valid mirrors in_valid two cycles later
    x = 16'h0001; y = 16'h0001; ctrl = 6'b000010;
    for (int k = 0; k < 6; k++) begin
      logic ev;
      in_valid = (k < 4) && (k % 2 == 0);
      if (in_valid) exp_q.push_back('{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      ev = (k >= 2) && (k < 6) && ((k - 2) % 2 == 0);
      chk("bubble_out_valid", 32'(out_valid), 32'(ev));
      cyc();
    end
    in_valid = 1'b0;
    drain();

    // 16-bit wraparound: result zero, carry out of the MSB
    in_valid = 1'b1; x = 16'hFFFF; y = 16'h0001; ctrl = 6'b000010;
    exp_q.push_back('{16'h0000, 1'b1, 1'b0, 1'b1, exp_carry, exp_ovf});
    cyc();
    in_valid = 1'b0;
    drain();

    // 8-bit signed overflow: 7F + 01
    in_valid8 = 1'b1; x8 = 8'h7F; y8 = 8'h01; ctrl8 = 6'b000010;
    cyc();
    in_valid8 = 1'b0;
    for (int k = 0; k < 6 && !out_valid8; k++) cyc();
    chk("w8_valid", 32'(out_valid8), 32'd1);
    chk("w8_out", 32'(out8), 32'h80);
    chk("w8_ng", 32'(ng8), 32'd1);
    chk("w8_zr", 32'(zr8), 32'd0);
    chk("w8_carry", 32'(carry8), 32'd0);
    chk("w8_ovf", 32'(ovf8), 32'(exp_ovf8));
    cyc();
    chk("w8_drained", 32'(out_valid8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
